// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory port bundle for mem_arbiter.
// slave = arbiter side, master = requesters and memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ready;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_wmask;
    logic              data_ready;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_wmask;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_ready, inst_rvalid, inst_rdata,
        input  data_req, data_we, data_addr,
        input  data_wdata, data_wmask,
        output data_ready, data_rvalid, data_rdata,
        output mem_req, mem_we, mem_addr,
        output mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_ready, inst_rvalid, inst_rdata,
        output data_req, data_we, data_addr,
        output data_wdata, data_wmask,
        input  data_ready, data_rvalid, data_rdata,
        input  mem_req, mem_we, mem_addr,
        input  mem_wdata, mem_wmask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port.
// Define ARB_ROUND_ROBIN_EN for alternating priority instead of starve guard.
module mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t            r_state;
    logic              r_sel_inst;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_mem_wmask;
    logic              r_inst_rvalid;
    logic              r_data_rvalid;
    logic [DATA_W-1:0] r_inst_rdata;
    logic [DATA_W-1:0] r_data_rdata;

    logic w_arb;
    logic w_inst_pri;
    logic w_inst_win;
    logic w_data_win;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_inst;
    assign w_inst_pri = !r_last_inst;
`else
    logic [3:0] r_starve;
    assign w_inst_pri = (r_starve >= 4'(STARVE_LIMIT));
`endif

    // Accept is a same-cycle decode of IDLE so ready lands in cycle 0.
    assign w_arb = (r_state == IDLE) && !reset
                && (bus.inst_req || bus.data_req);
    assign w_inst_win = w_arb && bus.inst_req
                     && (!bus.data_req || w_inst_pri);
    assign w_data_win = w_arb && !w_inst_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sel_inst    <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wmask   <= '0;
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_inst   <= 1'b1;
`else
            r_starve      <= '0;
`endif
        end else begin
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_state    <= GRANT;
                        r_sel_inst <= w_inst_win;
                        if (w_inst_win) begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= bus.inst_addr;
                            r_mem_wdata <= '0;
                            r_mem_wmask <= '0;
                        end else begin
                            r_mem_we    <= bus.data_we;
                            r_mem_addr  <= bus.data_addr;
                            r_mem_wdata <= bus.data_wdata;
                            r_mem_wmask <= bus.data_wmask;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_inst <= w_inst_win;
`else
                        if (w_inst_win) begin
                            r_starve <= '0;
                        end else if (bus.inst_req
                                  && r_starve != 4'hf) begin
                            r_starve <= r_starve + 4'd1;
                        end
`endif
                    end
                end
                GRANT: begin
                    r_mem_req <= 1'b1;
                    r_state   <= r_sel_inst ? BUSY_I : BUSY_D;
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                        if (r_state == BUSY_I) begin
                            r_inst_rvalid <= 1'b1;
                            r_inst_rdata  <= bus.mem_rdata;
                        end else begin
                            r_data_rvalid <= 1'b1;
                            r_data_rdata  <= bus.mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.inst_ready  = w_inst_win;
    assign bus.data_ready  = w_data_win;
    assign bus.inst_rvalid = r_inst_rvalid;
    assign bus.data_rvalid = r_data_rvalid;
    assign bus.inst_rdata  = r_inst_rdata;
    assign bus.data_rdata  = r_data_rdata;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_wmask   = r_mem_wmask;
endmodule
